pipe_stage_reg: RTL and testbench

Generic, parametrised pipeline stage register that replaces the fixed per-stage register pairs (datapath plus control) with one block.
- Carries a DATA_W datapath bundle and a CTRL_W control bundle between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake with a 2-entry skid buffer, so a stall propagates without a combinational ready path.
- Adds synchronous flush and bubble-control injection for hazard and branch handling.

---
 rtl/pipe_stage_reg.sv | 156 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Parametrised pipeline stage register, valid/ready with 2-entry
//            skid buffer, synchronous flush, bubble control on empty.
//            Optional perf counters enabled by macro PIPE_STAGE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
   parameter int                DATA_W      = 128,
   parameter int                CTRL_W      = 12,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`else
   output logic [CTRL_W-1:0] out_ctrl
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_in_ready;
   logic [DATA_W-1:0]   r_main_data;
   logic [CTRL_W-1:0]   r_main_ctrl;
   logic [DATA_W-1:0]   r_skid_data;
   logic [CTRL_W-1:0]   r_skid_ctrl;
   logic                w_main_valid;
   logic                w_skid_valid;
   logic                w_accept;
   logic                w_issue;
   logic                w_load_main_in;
   logic                w_load_main_skid;
   logic                w_load_skid;

   assign w_main_valid = (r_state != S_EMPTY);
   assign w_skid_valid = (r_state == S_TWO);
   assign w_accept     = in_valid & r_in_ready;
   assign w_issue      = w_main_valid & out_ready;

   assign in_ready  = r_in_ready;
   assign out_valid = w_main_valid;
   assign out_data  = r_main_data;
   assign out_ctrl  = w_main_valid ? r_main_ctrl : CTRL_BUBBLE;

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt    = S_ONE;
                  w_load_main_in = 1'b1;
               end
            end
            S_ONE: begin
               if (w_accept && w_issue) begin
                  w_load_main_in = 1'b1;
               end else if (w_accept) begin
                  w_state_nxt = S_TWO;
                  w_load_skid = 1'b1;
               end else if (w_issue) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               // in_ready is low here, so only the drain path exists
               if (w_issue) begin
                  w_state_nxt      = S_ONE;
                  w_load_main_skid = 1'b1;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // in_ready is registered from the next state so it never depends on inputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != S_TWO);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
         end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
         end
         if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
         end
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_main_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (flush && (w_main_valid || w_skid_valid) && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench for pipe_stage_reg against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam int          DATA_W   = 128;
   localparam int          CTRL_W   = 12;
   localparam logic [11:0] C_BUBBLE = 12'h5A5;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [15:0]       stall_cnt;
   logic [15:0]       flush_cnt;
   int unsigned       exp_stall;
   int unsigned       exp_flush;
`endif

   pipe_stage_reg #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .CTRL_BUBBLE (C_BUBBLE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef PIPE_STAGE_PERF_EN
      .out_ctrl  (out_ctrl),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`else
      .out_ctrl  (out_ctrl)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [CTRL_W-1:0] c;
   } ent_t;

   ent_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   // One clock cycle: check current outputs against the model, apply inputs,
   // advance the model by the queue rules, then take the rising edge.
   task automatic drive_cycle(input logic iv, input logic [DATA_W-1:0] d,
                              input logic [CTRL_W-1:0] c, input logic ordy,
                              input logic fl);
      logic  m_ready;
      logic  m_valid;
      ent_t  e;
      @(negedge clk);
      m_ready = (q.size() < 2);
      m_valid = (q.size() > 0);
      chk("in_ready", {127'd0, in_ready}, {127'd0, m_ready});
      chk("out_valid", {127'd0, out_valid}, {127'd0, m_valid});
      if (m_valid) begin
         chk("out_data", out_data, q[0].d);
         chk("out_ctrl", {116'd0, out_ctrl}, {116'd0, q[0].c});
      end else begin
         chk("out_ctrl_bubble", {116'd0, out_ctrl}, {116'd0, C_BUBBLE});
      end
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", {112'd0, stall_cnt}, {112'd0, exp_stall[15:0]});
      chk("flush_cnt", {112'd0, flush_cnt}, {112'd0, exp_flush[15:0]});
      if (m_valid && !ordy && exp_stall < 32'hFFFF) exp_stall++;
      if (fl && m_valid && exp_flush < 32'hFFFF) exp_flush++;
`endif
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      if (fl) begin
         q.delete();
      end else begin
         if (m_valid && ordy) void'(q.pop_front());
         if (iv && m_ready) begin
            e.d = d;
            e.c = c;
            q.push_back(e);
         end
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
   endtask

   // Called just after a rising edge: asserts reset between edges and checks
   // the outputs respond before any further clock edge.
   task automatic async_reset_now();
      #2;
      rst       = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_out_ctrl", {116'd0, out_ctrl}, {116'd0, C_BUBBLE});
      q.delete();
`ifdef PIPE_STAGE_PERF_EN
      exp_stall = 0;
      exp_flush = 0;
`endif
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      out_ready = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
      exp_stall = 0;
      exp_flush = 0;
`endif
      #1 rst = 1'b0;
      #11;
      chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
      chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
      chk("reset_out_data", out_data, 128'd0);
      chk("reset_out_ctrl", {116'd0, out_ctrl}, {116'd0, C_BUBBLE});
      @(negedge clk);
      rst = 1'b1;

      // streaming at full rate
      for (int i = 1; i <= 8; i++) drive_cycle(1'b1, DATA_W'(i), CTRL_W'(i), 1'b1, 1'b0);
      idle(3);

      // backpressure into the skid entry, then drain in order
      drive_cycle(1'b1, 128'hA, 12'h00A, 1'b0, 1'b0);
      drive_cycle(1'b1, 128'hB, 12'h00B, 1'b0, 1'b0);
      drive_cycle(1'b1, 128'hC, 12'h00C, 1'b0, 1'b0);
      drive_cycle(1'b1, 128'hC, 12'h00C, 1'b0, 1'b0);
      drive_cycle(1'b1, 128'hC, 12'h00C, 1'b1, 1'b0);
      drive_cycle(1'b1, 128'hC, 12'h00C, 1'b1, 1'b0);
      idle(3);

      // flush while full, with a new entry offered in the same cycle
      drive_cycle(1'b1, 128'h1A, 12'h01A, 1'b0, 1'b0);
      drive_cycle(1'b1, 128'h1B, 12'h01B, 1'b0, 1'b0);
      drive_cycle(1'b1, 128'hD, 12'h00D, 1'b0, 1'b1);
      idle(3);

      // asynchronous reset while stalled in the full state
      drive_cycle(1'b1, 128'h2A, 12'h02A, 1'b0, 1'b0);
      drive_cycle(1'b1, 128'h2B, 12'h02B, 1'b0, 1'b0);
      async_reset_now();
      idle(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive_cycle(1'($urandom_range(0, 3) != 0), rnd_data(), CTRL_W'($urandom()),
                     1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      end
      idle(3);

`ifdef PIPE_STAGE_PERF_EN
      async_reset_now();
      drive_cycle(1'b1, 128'h77, 12'h077, 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
      drive_cycle(1'b1, 128'h78, 12'h078, 1'b1, 1'b1);
      drive_cycle(1'b1, 128'h79, 12'h079, 1'b1, 1'b0);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      @(negedge clk);
      chk("stall_cnt_sat", {112'd0, stall_cnt}, {112'd0, 16'hFFFF});
      chk("flush_cnt_two", {112'd0, flush_cnt}, {112'd0, 16'd2});
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
